// File: rtl/sdc_data_rx.sv
// SD card DAT-line receive path: start-bit wait, block capture into 32-bit FIFO words, per-line CRC16 and stop-bit check.
// Build option SDC_DATA_RX_WIDE_BUS_EN adds 4-bit bus support; the default build receives on DAT0 only.
module sdc_data_rx #(
  parameter int unsigned BLKSIZE_W      = 12,
  parameter int unsigned DATA_TIMEOUT_W = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      startRx,
  input  logic                      abort,
  input  logic [BLKSIZE_W-1:0]      blockSize,
  input  logic [15:0]               blockCount,
  input  logic                      bus4bit,
  input  logic [DATA_TIMEOUT_W-1:0] timeoutValue,
  input  logic [3:0]                sdDat_i,
  output logic [31:0]               wrData,
  output logic                      wrEn,
  input  logic                      fifoFull,
  output logic [15:0]               blocksDone,
  output logic                      busy,
  output logic [4:0]                interruptEvents
);

`ifdef SDC_DATA_RX_WIDE_BUS_EN
  localparam int unsigned NLINES = 4;
`else
  localparam int unsigned NLINES = 1;
`endif
  localparam int unsigned BITCNT_W = BLKSIZE_W + 3;
  localparam int unsigned WORDS_W  = BLKSIZE_W - 2;

  typedef enum logic [2:0] {
    IDLE, WAIT_START, RX_DATA, RX_CRC, RX_STOP, BLK_END
  } state_t;

  state_t                    state;
  logic [3:0]                sdDat_i_reg;
  logic                      mode4;
  logic [BITCNT_W-1:0]       bit_cnt;
  logic [DATA_TIMEOUT_W-1:0] to_cnt;
  logic [3:0]                crc_cnt;
  logic [31:0]               shreg;
  logic                      crc_err;
  logic                      ovr_err;
  logic                      to_err;
  logic                      err_ev;

  logic [WORDS_W-1:0]        words;
  logic [BITCNT_W-1:0]       data_last;
  logic                      start_seen;
  logic                      word_done;
  logic [31:0]               shreg_next;
  logic [15:0]               blk_target;
  logic [NLINES-1:0]         line_bits;
  logic [NLINES-1:0]         line_used;
  logic [NLINES-1:0]         crc_msb;
  logic                      crc_mismatch;
  logic                      stop_bad;
  logic                      unused_bits;

`ifdef SDC_DATA_RX_WIDE_BUS_EN
  assign line_used   = mode4 ? 4'hF : 4'h1;
  assign unused_bits = ^blockSize[1:0];
`else
  assign mode4       = 1'b0;
  assign line_used   = 1'b1;
  assign unused_bits = ^{blockSize[1:0], bus4bit};
`endif

  // Block length in sampling cycles, minus one; blockSize[1:0] are treated as zero.
  assign words      = blockSize[BLKSIZE_W-1:2];
  assign data_last  = mode4 ? ({2'b00, words, 3'b000} - BITCNT_W'(1))
                            : ({words, 5'b00000} - BITCNT_W'(1));
  assign start_seen = mode4 ? (sdDat_i_reg == 4'h0) : ~sdDat_i_reg[0];
  assign word_done  = mode4 ? (bit_cnt[2:0] == 3'd7) : (bit_cnt[4:0] == 5'd31);
  assign shreg_next = mode4 ? {shreg[27:0], sdDat_i_reg} : {shreg[30:0], sdDat_i_reg[0]};
  assign blk_target = (blockCount == 16'd0) ? 16'd1 : blockCount;

  assign line_bits    = sdDat_i_reg[NLINES-1:0];
  assign crc_mismatch = |((line_bits ^ crc_msb) & line_used);
  assign stop_bad     = |(~line_bits & line_used);

  assign err_ev          = crc_err | ovr_err | to_err;
  assign busy            = (state != IDLE);
  assign interruptEvents = (state == IDLE) ? {crc_err, ovr_err, to_err, err_ev, ~err_ev} : 5'd0;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ d) r = r ^ 16'h1021;
    return r;
  endfunction

  // One CRC16 generator per line: fed with data, then shifted out MSB first for comparison.
  for (genvar g = 0; g < NLINES; g++) begin : g_crc
    logic [15:0] crc;
    always_ff @(posedge clk) begin
      if (rst || state == WAIT_START) begin
        crc <= 16'h0000;
      end else if (state == RX_DATA) begin
        crc <= crc16_step(crc, sdDat_i_reg[g]);
      end else if (state == RX_CRC) begin
        crc <= {crc[14:0], 1'b0};
      end
    end
    assign crc_msb[g] = crc[15];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sdDat_i_reg <= 4'hF;
      wrEn        <= 1'b0;
      wrData      <= 32'h0;
      blocksDone  <= 16'h0;
      crc_err     <= 1'b0;
      ovr_err     <= 1'b0;
      to_err      <= 1'b0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      crc_cnt     <= 4'h0;
      shreg       <= 32'h0;
`ifdef SDC_DATA_RX_WIDE_BUS_EN
      mode4       <= 1'b0;
`endif
    end else begin
      sdDat_i_reg <= sdDat_i;
      wrEn        <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (startRx && !abort) begin
              state      <= WAIT_START;
              crc_err    <= 1'b0;
              ovr_err    <= 1'b0;
              to_err     <= 1'b0;
              blocksDone <= 16'h0;
              to_cnt     <= '0;
`ifdef SDC_DATA_RX_WIDE_BUS_EN
              mode4      <= bus4bit;
`endif
            end
          end
          WAIT_START: begin
            bit_cnt <= '0;
            // The cycle count reaches timeoutValue exactly on the edge that leaves this state.
            if (start_seen) begin
              state <= RX_DATA;
            end else if (timeoutValue != '0 && to_cnt == timeoutValue - DATA_TIMEOUT_W'(1)) begin
              to_err <= 1'b1;
              state  <= IDLE;
            end else begin
              to_cnt <= to_cnt + DATA_TIMEOUT_W'(1);
            end
          end
          RX_DATA: begin
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt + BITCNT_W'(1);
            if (bit_cnt == data_last) begin
              state   <= RX_CRC;
              crc_cnt <= 4'h0;
            end
            // A full FIFO at word completion aborts the transfer and drops the word.
            if (word_done) begin
              if (fifoFull) begin
                ovr_err <= 1'b1;
                state   <= IDLE;
              end else begin
                wrEn   <= 1'b1;
                wrData <= shreg_next;
              end
            end
          end
          RX_CRC: begin
            if (crc_mismatch) crc_err <= 1'b1;
            crc_cnt <= crc_cnt + 4'd1;
            if (crc_cnt == 4'd15) state <= RX_STOP;
          end
          RX_STOP: begin
            if (stop_bad) crc_err <= 1'b1;
            state <= BLK_END;
          end
          BLK_END: begin
            if (crc_err) begin
              state <= IDLE;
            end else begin
              blocksDone <= blocksDone + 16'd1;
              if (blocksDone + 16'd1 == blk_target) begin
                state <= IDLE;
              end else begin
                state  <= WAIT_START;
                to_cnt <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdc_data_rx.sv
// Directed self-checking bench for sdc_data_rx: builds DAT-line streams with bench-computed CRC16s and checks words and status.
module tb_sdc_data_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        startRx;
  logic        abort;
  logic [11:0] blockSize;
  logic [15:0] blockCount;
  logic        bus4bit;
  logic [23:0] timeoutValue;
  logic [3:0]  sdDat_i;
  logic [31:0] wrData;
  logic        wrEn;
  logic        fifoFull;
  logic [15:0] blocksDone;
  logic        busy;
  logic [4:0]  interruptEvents;

  sdc_data_rx #(.BLKSIZE_W(12), .DATA_TIMEOUT_W(24)) dut (
    .clk(clk), .rst(rst), .startRx(startRx), .abort(abort),
    .blockSize(blockSize), .blockCount(blockCount), .bus4bit(bus4bit),
    .timeoutValue(timeoutValue), .sdDat_i(sdDat_i), .wrData(wrData),
    .wrEn(wrEn), .fifoFull(fifoFull), .blocksDone(blocksDone),
    .busy(busy), .interruptEvents(interruptEvents)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  stream[$];
  logic [7:0]  byte_q[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] tcrc[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every FIFO write away from the active edge.
  always @(negedge clk) if (wrEn === 1'b1) got_q.push_back(wrData);

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic d);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ d) r = r ^ 16'h1021;
    return r;
  endfunction

  function automatic logic [2:0] junk();
    return 3'(stream.size() * 5 + 3);
  endfunction

  task automatic push_data(input logic [3:0] s);
    for (int l = 0; l < 4; l++) tcrc[l] = crc_upd(tcrc[l], s[l]);
    stream.push_back(s);
  endtask

  // Appends start bit, data, per-line CRC (optional flipped bit), stop bit and idle gap.
  task automatic build_block(input bit four, input int first, input int nbytes,
                             input int flip_line, input int flip_bit, input bit bad_stop);
    logic [7:0] b;
    logic [3:0] s;
    for (int l = 0; l < 4; l++) tcrc[l] = 16'h0000;
    stream.push_back(four ? 4'h0 : 4'hA);
    for (int i = first; i < first + nbytes; i++) begin
      b = byte_q[i];
      if (four) begin
        push_data(b[7:4]);
        push_data(b[3:0]);
      end else begin
        for (int k = 7; k >= 0; k--) push_data({junk(), b[k]});
      end
    end
    for (int i = 15; i >= 0; i--) begin
      s = four ? 4'h0 : {junk(), 1'b0};
      for (int l = 0; l < 4; l++) begin
        if (four || l == 0) s[l] = tcrc[l][i];
        if (l == flip_line && i == flip_bit) s[l] = ~s[l];
      end
      stream.push_back(s);
    end
    if (four) stream.push_back(bad_stop ? 4'hB : 4'hF);
    else      stream.push_back({junk(), ~bad_stop});
    for (int i = 0; i < 3; i++) stream.push_back(four ? 4'hF : {junk(), 1'b1});
  endtask

  task automatic play(input int from, input int to);
    for (int i = from; i < to; i++) begin
      sdDat_i = stream[i];
      tick();
    end
    sdDat_i = 4'hF;
  endtask

  task automatic start_rx();
    startRx = 1'b1;
    tick();
    startRx = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic expect_words(input int first, input int nwords);
    for (int w = 0; w < nwords; w++)
      exp_q.push_back({byte_q[first + 4*w], byte_q[first + 4*w + 1],
                       byte_q[first + 4*w + 2], byte_q[first + 4*w + 3]});
  endtask

  task automatic check_words(input string tag);
    check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic new_test(input int bsize, input int bcount, input bit four);
    stream.delete(); got_q.delete(); exp_q.delete();
    blockSize = 12'(bsize); blockCount = 16'(bcount); bus4bit = four;
    sdDat_i = 4'hF; fifoFull = 1'b0; abort = 1'b0; startRx = 1'b0;
  endtask

  task automatic fill_seq(input int n);
    byte_q.delete();
    for (int i = 0; i < n; i++) byte_q.push_back(8'(i));
  endtask

  initial begin
    int n;
    rst = 1'b1; startRx = 1'b0; abort = 1'b0; blockSize = 12'd4; blockCount = 16'd1;
    bus4bit = 1'b0; timeoutValue = 24'd1000; sdDat_i = 4'hF; fifoFull = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wren", 32'(wrEn), 32'd0);
    check("rst_wrdata", wrData, 32'h0);
    check("rst_blocks", 32'(blocksDone), 32'd0);
    check("rst_irq", 32'(interruptEvents), 32'h01);

    // 1-bit, single 4-byte block
    new_test(4, 1, 1'b0);
    byte_q = '{8'hA5, 8'hC3, 8'h0F, 8'h12};
    build_block(1'b0, 0, 4, -1, 0, 1'b0);
    exp_q.push_back(32'hA5C30F12);
    start_rx();
    play(0, stream.size());
    wait_idle("one");
    check_words("one");
    check("one_irq", 32'(interruptEvents), 32'h01);
    check("one_blocks", 32'(blocksDone), 32'd1);

    // 1-bit, two 8-byte blocks
    new_test(8, 2, 1'b0);
    fill_seq(16);
    build_block(1'b0, 0, 8, -1, 0, 1'b0);
    build_block(1'b0, 8, 8, -1, 0, 1'b0);
    expect_words(0, 4);
    start_rx();
    play(0, stream.size());
    wait_idle("two");
    check_words("two");
    check("two_irq", 32'(interruptEvents), 32'h01);
    check("two_blocks", 32'(blocksDone), 32'd2);

    // 1-bit CRC error in the first of two blocks
    new_test(4, 2, 1'b0);
    fill_seq(4);
    build_block(1'b0, 0, 4, 0, 7, 1'b0);
    start_rx();
    play(0, stream.size());
    wait_idle("crc1");
    check("crc1_irq", 32'(interruptEvents), 32'h12);
    check("crc1_blocks", 32'(blocksDone), 32'd0);

    // Bad stop bit
    new_test(4, 1, 1'b0);
    fill_seq(4);
    build_block(1'b0, 0, 4, -1, 0, 1'b1);
    start_rx();
    play(0, stream.size());
    wait_idle("stop");
    check("stop_irq", 32'(interruptEvents), 32'h12);
    check("stop_blocks", 32'(blocksDone), 32'd0);

    // blockCount 0 behaves as 1
    new_test(4, 0, 1'b0);
    fill_seq(4);
    build_block(1'b0, 0, 4, -1, 0, 1'b0);
    start_rx();
    play(0, stream.size());
    wait_idle("cnt0");
    check("cnt0_irq", 32'(interruptEvents), 32'h01);
    check("cnt0_blocks", 32'(blocksDone), 32'd1);

    // Start-bit timeout of 100 cycles
    new_test(4, 1, 1'b0);
    timeoutValue = 24'd100;
    start_rx();
    check("to_irq_busy", 32'(interruptEvents), 32'h00);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("to_cycles", 32'(n), 32'd100);
    check("to_irq", 32'(interruptEvents), 32'h06);

    // Timeout disabled: waits indefinitely until aborted
    timeoutValue = 24'd0;
    start_rx();
    repeat (300) tick();
    check("to0_busy", 32'(busy), 32'd1);
    check("to0_irq", 32'(interruptEvents), 32'h00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("to0_abort_busy", 32'(busy), 32'd0);
    check("to0_abort_irq", 32'(interruptEvents), 32'h01);
    timeoutValue = 24'd1000;

    // abort beats startRx in IDLE
    abort = 1'b1; startRx = 1'b1;
    tick();
    abort = 1'b0; startRx = 1'b0;
    check("abort_start_busy", 32'(busy), 32'd0);

    // FIFO full at the first word
    new_test(4, 1, 1'b0);
    fill_seq(4);
    build_block(1'b0, 0, 4, -1, 0, 1'b0);
    fifoFull = 1'b1;
    start_rx();
    play(0, stream.size());
    wait_idle("ovr");
    check_words("ovr");
    check("ovr_irq", 32'(interruptEvents), 32'h0A);
    check("ovr_blocks", 32'(blocksDone), 32'd0);
    fifoFull = 1'b0;

    // abort in the middle of RX_DATA, after the first word
    new_test(8, 1, 1'b0);
    fill_seq(8);
    build_block(1'b0, 0, 8, -1, 0, 1'b0);
    expect_words(0, 1);
    start_rx();
    play(0, 41);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    play(41, stream.size());
    repeat (5) tick();
    check_words("abort");
    check("abort_irq", 32'(interruptEvents), 32'h01);
    check("abort_blocks", 32'(blocksDone), 32'd0);

    // rst in the middle of RX_CRC
    new_test(4, 1, 1'b0);
    fill_seq(4);
    build_block(1'b0, 0, 4, -1, 0, 1'b0);
    expect_words(0, 1);
    start_rx();
    play(0, 41);
    rst = 1'b1;
    tick();
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_wrdata", wrData, 32'h0);
    check("rstx_irq", 32'(interruptEvents), 32'h01);
    rst = 1'b0;
    play(41, stream.size());
    repeat (5) tick();
    check_words("rstx");
    check("rstx_blocks", 32'(blocksDone), 32'd0);

`ifdef SDC_DATA_RX_WIDE_BUS_EN
    // 4-bit, two 8-byte blocks
    new_test(8, 2, 1'b1);
    fill_seq(16);
    build_block(1'b1, 0, 8, -1, 0, 1'b0);
    build_block(1'b1, 8, 8, -1, 0, 1'b0);
    expect_words(0, 4);
    start_rx();
    play(0, stream.size());
    wait_idle("w4");
    check_words("w4");
    check("w4_irq", 32'(interruptEvents), 32'h01);
    check("w4_blocks", 32'(blocksDone), 32'd2);

    // 4-bit CRC bit flipped on DAT2 in block 1
    new_test(8, 2, 1'b1);
    fill_seq(8);
    build_block(1'b1, 0, 8, 2, 5, 1'b0);
    start_rx();
    play(0, stream.size());
    wait_idle("w4crc");
    check("w4crc_irq", 32'(interruptEvents), 32'h12);
    check("w4crc_blocks", 32'(blocksDone), 32'd0);
`else
    // Without the wide-bus build, bus4bit is ignored and reception stays on DAT0
    new_test(4, 1, 1'b1);
    byte_q = '{8'h3C, 8'h5A, 8'h96, 8'hE1};
    build_block(1'b0, 0, 4, -1, 0, 1'b0);
    exp_q.push_back(32'h3C5A96E1);
    start_rx();
    play(0, stream.size());
    wait_idle("n4");
    check_words("n4");
    check("n4_irq", 32'(interruptEvents), 32'h01);
    check("n4_blocks", 32'(blocksDone), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
